// File: rtl/tdc_code_accum.sv
// tdc_code_accum: windowed sum/mean/min/max of TDC pop-count codes.
// Collects 2^LOG2_SAMPLES clamped codes per window. It publishes the window
// results with a one-cycle valid pulse. All outputs come from registers.
module tdc_code_accum #(
    parameter  int N            = 64,
    parameter  int LOG2_SAMPLES = 4,
    localparam int W            = $clog2(N) + 1,
    localparam int SW           = W + LOG2_SAMPLES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [W-1:0]  code,
    output logic [SW-1:0] sum,
    output logic [W-1:0]  mean,
    output logic [W-1:0]  code_min,
    output logic [W-1:0]  code_max,
    output logic          valid,
    output logic          busy,
    output logic          ovr
);

    localparam logic [W-1:0]            N_CODE  = W'(N);
    localparam logic [LOG2_SAMPLES-1:0] CNT_ONE = LOG2_SAMPLES'(1);

    // Smaller of two codes.
    function automatic logic [W-1:0] min_code(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Larger of two codes.
    function automatic logic [W-1:0] max_code(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [LOG2_SAMPLES-1:0] cnt_r;
    logic [SW-1:0]           acc_r;
    logic [W-1:0]            run_min_r;
    logic [W-1:0]            run_max_r;
    logic [SW-1:0]           sum_r;
    logic [W-1:0]            mean_r;
    logic [W-1:0]            code_min_r;
    logic [W-1:0]            code_max_r;
    logic                    valid_r;
    logic                    busy_r;
    logic                    ovr_r;

    logic                    over_s;
    logic [W-1:0]            cs_s;
    logic                    first_s;
    logic                    last_s;
    logic [LOG2_SAMPLES-1:0] cnt_inc_s;
    logic [SW-1:0]           acc_nxt_s;
    logic [W-1:0]            min_nxt_s;
    logic [W-1:0]            max_nxt_s;

    // Clamp the incoming code and form the running values after accepting it.
    always_comb begin
        over_s    = (code > N_CODE);
        cs_s      = code;
        first_s   = (cnt_r == '0);
        last_s    = (cnt_r == '1);
        cnt_inc_s = cnt_r + CNT_ONE;
        acc_nxt_s = SW'(code);
        min_nxt_s = code;
        max_nxt_s = code;
        if (over_s) begin
            cs_s = N_CODE;
        end else begin
            cs_s = code;
        end
        if (first_s) begin
            // First sample of a window reloads everything; stale run values are ignored.
            acc_nxt_s = SW'(cs_s);
            min_nxt_s = cs_s;
            max_nxt_s = cs_s;
        end else begin
            acc_nxt_s = acc_r + SW'(cs_s);
            min_nxt_s = min_code(run_min_r, cs_s);
            max_nxt_s = max_code(run_max_r, cs_s);
        end
    end

    // Window state, result registers and sticky overrange flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= '0;
            acc_r      <= '0;
            run_min_r  <= '0;
            run_max_r  <= '0;
            sum_r      <= '0;
            mean_r     <= '0;
            code_min_r <= '0;
            code_max_r <= '0;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            ovr_r      <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            // Overrange is flagged even for a sample that clr discards.
            if (en && over_s) begin
                ovr_r <= 1'b1;
            end else begin
                ovr_r <= ovr_r;
            end
            if (clr) begin
                cnt_r  <= '0;
                busy_r <= 1'b0;
            end else if (en) begin
                cnt_r     <= cnt_inc_s;
                busy_r    <= (cnt_inc_s != '0);
                acc_r     <= acc_nxt_s;
                run_min_r <= min_nxt_s;
                run_max_r <= max_nxt_s;
                if (last_s) begin
                    sum_r      <= acc_nxt_s;
                    mean_r     <= acc_nxt_s[SW-1:LOG2_SAMPLES];
                    code_min_r <= min_nxt_s;
                    code_max_r <= max_nxt_s;
                    valid_r    <= 1'b1;
                end else begin
                    sum_r <= sum_r;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign sum      = sum_r;
    assign mean     = mean_r;
    assign code_min = code_min_r;
    assign code_max = code_max_r;
    assign valid    = valid_r;
    assign busy     = busy_r;
    assign ovr      = ovr_r;

endmodule

// File: doc/tdc_code_accum.md
# tdc_code_accum

Windowed accumulator that sits directly downstream of the TDC population-count stage. It consumes one registered thermometer pop-count code per enabled cycle and collects 2^LOG2_SAMPLES codes per window. For each window it reports the sum, the truncated mean, the minimum and the maximum, with a one-cycle valid pulse. Its purpose is to average out delay-line jitter before readout over the TinyTapeout I/O.

## Interface
- N, 64: delay-line tap count of the upstream stage. Code width W = $clog2(N)+1; legal codes are 0..N.
- LOG2_SAMPLES, 4: window length is S = 2^LOG2_SAMPLES samples. Legal range 1..8.
- clk  in  1  single clock for all state.
- rst  in  1  reset; synchronous, active-high. Sampled on posedge clk only.
- en  in  1  code is a valid sample this cycle. Driven by the same enable that loaded the pop-count output register, delayed one cycle.
- clr  in  1  abort the current window and restart it at zero.
- code  in  W  pop-count sample.
- sum  out  W+LOG2_SAMPLES  sum of the last completed window.
- mean  out  W  sum >> LOG2_SAMPLES, truncated toward zero.
- code_min  out  W  minimum clamped sample of the last completed window.
- code_max  out  W  maximum clamped sample of the last completed window.
- valid  out  1  one-cycle pulse: new window results on sum/mean/code_min/code_max.
- busy  out  1  at least one sample accumulated in the current, uncompleted window.
- ovr  out  1  sticky: some sample had code > N. Cleared only by rst.

## Operation
- Internal state:
  - cnt: LOG2_SAMPLES bits, counts accepted samples in the window.
  - acc: W+LOG2_SAMPLES bits, running sum.
  - run_min, run_max: W bits each.
- Clamping: cs = (code > N) ? N : code. When code > N and en=1, ovr is set the same edge. All accumulation uses cs.
- Accepting a sample (en=1, clr=0, rst=0):
  - If cnt==0, the sample starts a fresh window: acc<=cs, run_min<=cs, run_max<=cs.
  - Otherwise: acc<=acc+cs, run_min<=min(run_min,cs), run_max<=max(run_max,cs).
  - cnt<=cnt+1, wrapping modulo S.
- Window completion: when a sample is accepted with cnt==S-1, on that edge:
  - sum<=acc+cs.
  - mean<=(acc+cs)>>LOG2_SAMPLES.
  - code_min<=min(run_min,cs); code_max<=max(run_max,cs).
  - valid<=1; cnt wraps to 0.
  - The next accepted sample starts a new window with no dead cycle.
- Width rule: the maximum sum is N*S and always fits in W+LOG2_SAMPLES bits. No overflow is possible.
- busy = (cnt != 0), registered.
- valid is 0 on every edge that does not complete a window.
- clr=1, rst=0:
  - cnt<=0 and the window restarts; the sample presented that cycle is discarded even if en=1.
  - sum/mean/code_min/code_max hold their last values; valid<=0.
  - ovr unaffected; ovr is still set if en=1 and code > N.
- en=0: all state holds; valid<=0.
- rst=1, which overrides everything: cnt, acc, sum, mean, code_min, code_max, valid, busy and ovr all go to 0. run_min and run_max go to 0 and are don't-care until cnt==0 reloads them.
- Reset mid-window: the partial window is lost. No valid is produced for it.

## Timing
- Sample accepted on edge k with cnt==S-1: results and valid=1 are visible after edge k, exactly one cycle after the final sample is presented.
- Full throughput: en may be high every cycle. Back-to-back windows give a valid pulse every S cycles.
- Outputs change only on a completing edge or on rst. Between pulses they are stable and safe to sample asynchronously by readout logic.
- No combinational path from inputs to outputs.

## Test plan
- N=64, L=4, rst then 16 consecutive en cycles with code=10 -> valid high exactly once, the cycle after the 16th sample. Results: sum=160, mean=10, code_min=code_max=10, busy=0 afterward, ovr=0.
- Codes 0,1,…,15 with en gaps of 0–3 random cycles between samples -> one valid pulse only. Results: sum=120, mean=7, code_min=0, code_max=15. Outputs stable through the gaps.
- 32 back-to-back samples: first window all 64, second window all 3 -> two valid pulses 16 cycles apart. First: sum=1024, mean=64. Second: sum=48, mean=3, code_min=code_max=3.
- 8 samples of 20, then clr with en=1 and code=99, then 16 samples of 5 -> no valid until the 16th sample of 5. Results: sum=80, mean=5. The 20s and the 99 are excluded; ovr=1 because 99 > 64.
- Single sample code=70 inside a window of fifteen 0s -> ovr=1 (sticky), code_max=64, sum=64, mean=4.
- rst asserted after 9 samples, then 16 samples of 1 -> all outputs 0 during reset, busy=0. Next valid gives sum=16, mean=1.
